// File: rtl/seg_pkg.sv
// Shared types and glyph helpers for the multiplexed 7-segment scan driver.
// Glyphs are active-high, ordered g..a in bits 6..0.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } convState_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    case (nibble)
      4'h0:    seg_encode = 7'h3F;
      4'h1:    seg_encode = 7'h06;
      4'h2:    seg_encode = 7'h5B;
      4'h3:    seg_encode = 7'h4F;
      4'h4:    seg_encode = 7'h66;
      4'h5:    seg_encode = 7'h6D;
      4'h6:    seg_encode = 7'h7D;
      4'h7:    seg_encode = 7'h07;
      4'h8:    seg_encode = 7'h7F;
      4'h9:    seg_encode = 7'h6F;
      4'hA:    seg_encode = 7'h77;
      4'hB:    seg_encode = 7'h7C;
      4'hC:    seg_encode = 7'h39;
      4'hD:    seg_encode = 7'h5E;
      4'hE:    seg_encode = 7'h79;
      4'hF:    seg_encode = 7'h71;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle for
// NUM_W cycles, then a single COMMIT cycle where oDone flags a valid oBcd.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int NUM_W = 24,
  parameter int BCD_W = 24
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic [NUM_W-1:0] iBin,
  output logic [BCD_W-1:0] oBcd,
  output logic             oBusy,
  output logic             oDone
);

  localparam int CW = $clog2(NUM_W);

  convState_t       state_r, state_s;
  logic [NUM_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r, adj_s;
  logic [CW-1:0]    cnt_r;
  logic             busy_r, done_r;

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (iStart) state_s = ST_SHIFT; else state_s = ST_IDLE;
      ST_SHIFT:  if (cnt_r == CW'(NUM_W - 1)) state_s = ST_COMMIT; else state_s = ST_SHIFT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // add-3 correction on every BCD nibble of 5 or more
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      else                         adj_s[4*i +: 4] = bcd_r[4*i +: 4];
    end
  end

  // state, datapath and registered status flags
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_IDLE;
      bin_r   <= '0;
      bcd_r   <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_COMMIT);
      if (state_r == ST_IDLE && iStart) begin
        bin_r <= iBin;
        bcd_r <= '0;
        cnt_r <= '0;
      end else if (state_r == ST_SHIFT) begin
        bcd_r <= {adj_s[BCD_W-2:0], bin_r[NUM_W-1]};
        bin_r <= {bin_r[NUM_W-2:0], 1'b0};
        cnt_r <= cnt_r + CW'(1);
      end else begin
        bcd_r <= bcd_r;
      end
    end
  end

  assign oBcd  = bcd_r;
  assign oBusy = busy_r;
  assign oDone = done_r;

endmodule

// File: rtl/seg_scan_multi.sv
// Common-anode multiplexed 7-segment scan driver with hex/decimal display,
// leading-zero blanking, per-digit decimal points and per-digit blink.
module seg_scan_multi
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int NUM_W        = 24,
  parameter int SCAN_DIV     = 65536,
  parameter int BLINK_ROUNDS = 64
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [NUM_W-1:0]  iNum,
  input  logic              iIsHex,
  input  logic              iLoad,
  input  logic              iLzb,
  input  logic [DIGITS-1:0] iDp,
  input  logic [DIGITS-1:0] iBlink,
  output logic [7:0]        oSeg,
  output logic [DIGITS-1:0] oSel,
  output logic              oBusy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = $clog2(BLINK_ROUNDS + 1);
  localparam int unsigned OVF_LIM = 10 ** DIGITS;

  logic [CNT_W-1:0]  scanCnt_r;
  logic [IDX_W-1:0]  digIdx_r, nextIdx_s;
  logic [BLK_W-1:0]  blinkCnt_r;
  logic              blinkPh_r, nextPh_s, scanTc_s, wrap_s;
  logic [BCD_W-1:0]  disp_r, bcd_s;
  logic              ovf_r, lzb_r, convBusy_s, convDone_s, hexLoad_s, start_s;
  logic [DIGITS-1:0] lead_s, sel_s;
  logic [3:0]        nib_s;
  logic [7:0]        seg_s;
  logic              run_s;

  assign hexLoad_s = iLoad & iIsHex & ~convBusy_s;
  assign start_s   = iLoad & ~iIsHex & ~convBusy_s;
  assign oBusy     = convBusy_s;

  seg_bin2bcd #(.NUM_W(NUM_W), .BCD_W(BCD_W)) uConv (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iStart(start_s),
    .iBin  (iNum),
    .oBcd  (bcd_s),
    .oBusy (convBusy_s),
    .oDone (convDone_s)
  );

  // scan/blink next-state; outputs are built from the post-edge index and phase
  always_comb begin
    scanTc_s = (scanCnt_r == CNT_W'(SCAN_DIV - 1));
    wrap_s   = scanTc_s && (digIdx_r == IDX_W'(DIGITS - 1));
    if (wrap_s)        nextIdx_s = '0;
    else if (scanTc_s) nextIdx_s = digIdx_r + IDX_W'(1);
    else               nextIdx_s = digIdx_r;
    if (wrap_s && blinkCnt_r == BLK_W'(BLINK_ROUNDS - 1)) nextPh_s = ~blinkPh_r;
    else                                                  nextPh_s = blinkPh_r;
  end

  // scan counter, digit index and blink timing
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scanCnt_r  <= '0;
      digIdx_r   <= '0;
      blinkCnt_r <= '0;
      blinkPh_r  <= 1'b0;
    end else begin
      scanCnt_r <= scanTc_s ? '0 : scanCnt_r + CNT_W'(1);
      digIdx_r  <= nextIdx_s;
      blinkPh_r <= nextPh_s;
      if (wrap_s && blinkCnt_r == BLK_W'(BLINK_ROUNDS - 1)) blinkCnt_r <= '0;
      else if (wrap_s)                                      blinkCnt_r <= blinkCnt_r + BLK_W'(1);
      else                                                  blinkCnt_r <= blinkCnt_r;
    end
  end

  // display register: hex loads land immediately, decimal at converter commit
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      disp_r <= '0;
      ovf_r  <= 1'b0;
      lzb_r  <= 1'b0;
    end else if (hexLoad_s) begin
      disp_r <= BCD_W'(iNum);
      ovf_r  <= 1'b0;
      lzb_r  <= iLzb;
    end else if (start_s) begin
      ovf_r  <= (32'(iNum) >= OVF_LIM);
      lzb_r  <= iLzb;
    end else if (convDone_s) begin
      disp_r <= bcd_s;
    end else begin
      disp_r <= disp_r;
    end
  end

  // glyph selection: blink beats dash, dash beats blanking, blanking beats glyph
  always_comb begin
    run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_s     = run_s & (disp_r[4*i +: 4] == 4'h0);
      lead_s[i] = run_s;
    end
    nib_s = disp_r[{nextIdx_s, 2'b00} +: 4];
    sel_s = ~(DIGITS'(1) << nextIdx_s);
    if (nextPh_s && iBlink[nextIdx_s])
      seg_s = 8'hFF;
    else if (ovf_r)
      seg_s = ~{iDp[nextIdx_s], SEG_DASH};
    else if (lzb_r && lead_s[nextIdx_s] && nextIdx_s != IDX_W'(0))
      seg_s = ~{iDp[nextIdx_s], SEG_BLANK};
    else
      seg_s = ~{iDp[nextIdx_s], seg_encode(nib_s)};
  end

  // registered pin drivers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oSeg <= 8'hFF;
      oSel <= '1;
    end else begin
      oSeg <= seg_s;
      oSel <= sel_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Self-checking bench for seg_scan_multi: random hex/decimal loads checked
// against an arithmetic model of digits, blanking, blink and scan position.
module tb_seg_scan_multi;

  localparam int D = 6, NW = 24, SD = 4, BR = 2;
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          iCLK = 1'b0, iRST_N = 1'b0, iIsHex = 1'b0, iLoad = 1'b0, iLzb = 1'b0;
  logic [NW-1:0] iNum = '0;
  logic [D-1:0]  iDp = '0, iBlink = '0;
  logic [7:0]    oSeg;
  logic [D-1:0]  oSel;
  logic          oBusy;

  int checks = 0, errors = 0, cyc = 0;
  int mDig [D];
  bit mOvf = 1'b0, mLzb = 1'b0;

  seg_scan_multi #(.DIGITS(D), .NUM_W(NW), .SCAN_DIV(SD), .BLINK_ROUNDS(BR)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iNum(iNum), .iIsHex(iIsHex), .iLoad(iLoad),
    .iLzb(iLzb), .iDp(iDp), .iBlink(iBlink), .oSeg(oSeg), .oSel(oSel), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) cyc <= 0;
    else         cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_seg(int d, int k);
    logic [6:0] g;
    bit allZero;
    if (((k / (SD * D * BR)) % 2) == 1 && iBlink[d]) return 8'hFF;
    allZero = 1'b1;
    for (int j = d; j < D; j++) if (mDig[j] != 0) allZero = 1'b0;
    if (mOvf)                           g = 7'h40;
    else if (mLzb && d != 0 && allZero) g = 7'h00;
    else                                g = GLY[mDig[d]];
    return ~{iDp[d], g};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < D; i++) mDig[i] = 0;
    mOvf = 1'b0; mLzb = 1'b0;
  endfunction

  task automatic scan_check(int n, string name);
    int d;
    logic [D-1:0] es;
    logic [7:0] eg;
    repeat (n) begin
      @(negedge iCLK);
      d  = (cyc / SD) % D;
      es = ~(D'(1) << d);
      eg = exp_seg(d, cyc);
      checks++;
      if (oSel !== es || oSeg !== eg || oBusy !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc=%0d: oSel=%h oSeg=%h oBusy=%b, expected oSel=%h oSeg=%h oBusy=0",
                 name, cyc, oSel, oSeg, oBusy, es, eg);
      end
    end
  endtask

  task automatic load_hex(logic [NW-1:0] v, bit lzb);
    @(negedge iCLK);
    iNum = v; iIsHex = 1'b1; iLzb = lzb; iLoad = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL hex_busy: oBusy=%b expected 0", oBusy);
    end
    for (int i = 0; i < D; i++) mDig[i] = (v >> (4 * i)) & 15;
    mOvf = 1'b0; mLzb = lzb;
    @(negedge iCLK);
  endtask

  task automatic load_dec(int unsigned v, bit lzb, bit extra);
    int cnt;
    int unsigned p;
    bit done;
    @(negedge iCLK);
    iNum = NW'(v); iIsHex = 1'b0; iLzb = lzb; iLoad = 1'b1;
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge iCLK);
      iLoad = 1'b0;
      if (extra && i == 10) begin iNum = NW'(5); iLzb = 1'b0; iLoad = 1'b1; end
      if (oBusy === 1'b1) cnt++;
      else done = 1'b1;
    end
    iLoad = 1'b0;
    checks++;
    if (cnt != NW + 1 || !done) begin
      errors++;
      $display("FAIL dec_busy_len value=%0d: busy cycles=%0d expected %0d", v, cnt, NW + 1);
    end
    p = 1;
    for (int i = 0; i < D; i++) begin mDig[i] = (v / p) % 10; p = p * 10; end
    mOvf = (v >= 1000000); mLzb = lzb;
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge iCLK);
    checks++;
    if (oSeg !== 8'hFF || oSel !== 6'h3F || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: oSeg=%h oSel=%h oBusy=%b expected FF 3F 0", oSeg, oSel, oBusy);
    end
    iRST_N = 1'b1;
    scan_check(37, "after_reset");
    iRST_N = 1'b0;
    #1;
    checks++;
    if (oSeg !== 8'hFF || oSel !== 6'h3F || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan: oSeg=%h oSel=%h oBusy=%b expected FF 3F 0", oSeg, oSel, oBusy);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(posedge iCLK); #1;
    checks++;
    if (oSel !== 6'h3E) begin
      errors++;
      $display("FAIL reset_first_sel: oSel=%h expected 3E", oSel);
    end
    scan_check(20, "post_release");
  endtask

  task automatic test_hex();
    load_hex(24'h12AB3F, 1'b0);
    scan_check(60, "hex_12AB3F");
    for (int t = 0; t < 4; t++) begin
      load_hex(NW'($urandom) >> $urandom_range(0, 20), 1'($urandom));
      scan_check(30, "hex_random");
    end
  endtask

  task automatic test_decimal();
    load_dec(999999, 1'b0, 1'b1);
    scan_check(30, "dec_999999");
    for (int t = 0; t < 4; t++) begin
      load_dec($urandom_range(0, 999999) >> $urandom_range(0, 16), 1'($urandom), 1'b0);
      scan_check(30, "dec_random");
    end
  endtask

  task automatic test_overflow_lzb();
    load_dec(1000000, 1'b0, 1'b0);
    scan_check(30, "overflow_dash");
    load_dec(42, 1'b1, 1'b0);
    scan_check(30, "lzb_42");
    load_dec(0, 1'b1, 1'b0);
    scan_check(30, "lzb_zero");
    load_dec($urandom_range(1000000, 16777215), 1'b1, 1'b0);
    scan_check(30, "overflow_random");
    load_hex(24'h00A000, 1'b1);
    scan_check(30, "hex_clears_ovf");
  endtask

  task automatic test_blink_dp();
    load_hex(24'h000705, 1'b1);
    iBlink = 6'b000001; iDp = 6'b000010;
    scan_check(220, "blink_dp");
    iBlink = 6'($urandom); iDp = 6'($urandom);
    scan_check(120, "blink_dp_random");
    iBlink = '0; iDp = '0;
  endtask

  task automatic test_reset_during_conversion();
    @(negedge iCLK);
    iNum = NW'(654321); iIsHex = 1'b0; iLoad = 1'b1;
    @(negedge iCLK);
    iLoad = 1'b0;
    repeat (9) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    checks++;
    if (oBusy !== 1'b0 || oSeg !== 8'hFF || oSel !== 6'h3F) begin
      errors++;
      $display("FAIL reset_conv: oBusy=%b oSeg=%h oSel=%h expected 0 FF 3F", oBusy, oSeg, oSel);
    end
    model_reset();
    @(negedge iCLK);
    iRST_N = 1'b1;
    scan_check(60, "no_stale_commit");
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow_lzb();
    test_blink_dp();
    test_reset_during_conversion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
